// File: rtl/video_sink_checker.sv
// Receive-side monitor for a VGA-style stream: measures active pixels/lines, locks on
// consecutive good frames and reports errors. Optional per-frame signature: VIDEO_SIG_EN.
module video_sink_checker #(
  parameter int HDISP       = 800,
  parameter int VDISP       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic        video_hs,
  input  logic        video_vs,
  input  logic        video_blank,
  input  logic [23:0] video_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        line_err,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
  output logic [11:0] meas_hact,
  output logic [10:0] meas_vact,
  output logic [31:0] frame_sig
);

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    MEASURE   = 2'd1,
    LOCKED    = 2'd2
  } state_t;

  localparam logic [11:0] HDISP_W = 12'(HDISP);
  localparam logic [10:0] VDISP_W = 11'(VDISP);
  localparam logic [3:0]  LOCK_W  = 4'(LOCK_FRAMES);

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    if (v == 12'hFFF) sat_inc12 = v;
    else              sat_inc12 = v + 12'd1;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    if (v == 11'h7FF) sat_inc11 = v;
    else              sat_inc11 = v + 11'd1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) sat_inc8 = v;
    else            sat_inc8 = v + 8'd1;
  endfunction

  logic        s1_hs_r, s1_vs_r, s1_blank_r;
  logic        s2_hs_r, s2_vs_r, s2_blank_r;
  logic [23:0] s1_rgb_r;
  logic        vs_fall_s, run_end_s, run_start_s, hs_fall_s;
  logic        unused_s;

  logic [11:0] hcnt_r;
  logic [10:0] vcnt_r;
  logic        bad_r;
  logic        line_bad_s, close_good_s, close_s;
  logic [10:0] close_vcnt_s;
  logic [31:0] close_sig_s;

  state_t      state_r, state_nxt_s;
  logic [3:0]  good_cnt_r, good_nxt_s, good_inc_s;

  logic        pend_r, pend_ok_r;
  logic [10:0] pend_vact_r;
  logic [31:0] pend_sig_r;

  // two-stage input sampling; edges are taken between the stages
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      s1_hs_r    <= 1'b0;
      s1_vs_r    <= 1'b0;
      s1_blank_r <= 1'b0;
      s1_rgb_r   <= 24'h000000;
      s2_hs_r    <= 1'b0;
      s2_vs_r    <= 1'b0;
      s2_blank_r <= 1'b0;
    end else begin
      s1_hs_r    <= video_hs;
      s1_vs_r    <= video_vs;
      s1_blank_r <= video_blank;
      s1_rgb_r   <= video_rgb;
      s2_hs_r    <= s1_hs_r;
      s2_vs_r    <= s1_vs_r;
      s2_blank_r <= s1_blank_r;
    end
  end

  assign vs_fall_s   = s2_vs_r & ~s1_vs_r;
  assign run_end_s   = s2_blank_r & ~s1_blank_r;
  assign run_start_s = ~s2_blank_r & s1_blank_r;
  assign hs_fall_s   = s2_hs_r & ~s1_hs_r;

  // active-run length; the run-start cycle already holds the first pixel
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst)        hcnt_r <= 12'd0;
    else if (run_start_s) hcnt_r <= 12'd1;
    else if (s1_blank_r)  hcnt_r <= sat_inc12(hcnt_r);
    else                  hcnt_r <= hcnt_r;
  end

  // view of the closing frame, folding in a run that ends on the VS-fall cycle
  always_comb begin
    line_bad_s   = 1'b0;
    close_vcnt_s = vcnt_r;
    if (run_end_s) begin
      line_bad_s   = (hcnt_r != HDISP_W);
      close_vcnt_s = sat_inc11(vcnt_r);
    end else begin
      line_bad_s   = 1'b0;
      close_vcnt_s = vcnt_r;
    end
    close_good_s = !(bad_r || line_bad_s || s1_blank_r) && (close_vcnt_s == VDISP_W);
    close_s      = vs_fall_s && (state_r != SYNC_WAIT);
  end

  // per-frame line count and bad flag, restarted at every VS fall
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      vcnt_r <= 11'd0;
      bad_r  <= 1'b0;
    end else if (vs_fall_s) begin
      vcnt_r <= 11'd0;
      bad_r  <= 1'b0;
    end else if (run_end_s) begin
      vcnt_r <= close_vcnt_s;
      bad_r  <= bad_r | line_bad_s;
    end else begin
      vcnt_r <= vcnt_r;
      bad_r  <= bad_r;
    end
  end

`ifdef VIDEO_SIG_EN
  logic [31:0] acc_r, acc_step_s;

  function automatic logic [31:0] sig_step(input logic [31:0] acc, input logic [23:0] rgb);
    sig_step = {acc[30:0], acc[31]} ^ {8'h00, rgb};
  endfunction

  // the pixel present on the VS-fall cycle belongs to the closing frame
  always_comb begin
    acc_step_s = sig_step(acc_r, s1_rgb_r);
    if (s1_blank_r) close_sig_s = acc_step_s;
    else            close_sig_s = acc_r;
  end

  // signature accumulator
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst)       acc_r <= 32'h0000_0000;
    else if (vs_fall_s)  acc_r <= 32'h0000_0000;
    else if (s1_blank_r) acc_r <= acc_step_s;
    else                 acc_r <= acc_r;
  end

  assign unused_s = hs_fall_s;
`else
  assign close_sig_s = 32'h0000_0000;
  assign unused_s    = hs_fall_s ^ (^s1_rgb_r);
`endif

  assign good_inc_s = good_cnt_r + 4'd1;

  // lock state machine, evaluated only at VS falls
  always_comb begin
    state_nxt_s = state_r;
    good_nxt_s  = good_cnt_r;
    case (state_r)
      SYNC_WAIT: begin
        if (vs_fall_s) state_nxt_s = MEASURE;
        else           state_nxt_s = SYNC_WAIT;
      end
      MEASURE: begin
        if (vs_fall_s && close_good_s) begin
          good_nxt_s = good_inc_s;
          if (good_inc_s >= LOCK_W) state_nxt_s = LOCKED;
          else                      state_nxt_s = MEASURE;
        end else if (vs_fall_s) begin
          good_nxt_s  = 4'd0;
          state_nxt_s = MEASURE;
        end else begin
          state_nxt_s = MEASURE;
        end
      end
      LOCKED: begin
        if (vs_fall_s && !close_good_s) begin
          good_nxt_s  = 4'd0;
          state_nxt_s = MEASURE;
        end else begin
          state_nxt_s = LOCKED;
        end
      end
      default: begin
        state_nxt_s = SYNC_WAIT;
        good_nxt_s  = 4'd0;
      end
    endcase
  end

  // state register
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      state_r    <= SYNC_WAIT;
      good_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      good_cnt_r <= good_nxt_s;
    end
  end

  // closing-frame snapshot, published one cycle later together with locked
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      pend_r      <= 1'b0;
      pend_ok_r   <= 1'b0;
      pend_vact_r <= 11'd0;
      pend_sig_r  <= 32'h0000_0000;
    end else begin
      pend_r <= close_s;
      if (close_s) begin
        pend_ok_r   <= close_good_s;
        pend_vact_r <= close_vcnt_s;
        pend_sig_r  <= close_sig_s;
      end
    end
  end

  // registered status outputs
  always_ff @(posedge pixel_clk) begin
    if (pixel_rst) begin
      locked     <= 1'b0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      line_err   <= 1'b0;
      frame_cnt  <= 16'd0;
      err_cnt    <= 8'd0;
      meas_hact  <= 12'd0;
      meas_vact  <= 11'd0;
      frame_sig  <= 32'h0000_0000;
    end else begin
      locked     <= (state_r == LOCKED);
      frame_done <= pend_r;
      frame_ok   <= pend_r & pend_ok_r;
      if (pend_r) begin
        meas_vact <= pend_vact_r;
        frame_cnt <= frame_cnt + 16'd1;
        frame_sig <= pend_sig_r;
        if (!pend_ok_r) err_cnt <= sat_inc8(err_cnt);
      end
      if (run_end_s && (state_r != SYNC_WAIT)) begin
        meas_hact <= hcnt_r;
        if (hcnt_r != HDISP_W) line_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_video_sink_checker.sv
// Directed bench for video_sink_checker (HDISP=16, VDISP=8, LOCK_FRAMES=2) with a frame scoreboard.
module tb_video_sink_checker;
  localparam int HD = 16;
  localparam int VD = 8;
  localparam int LF = 2;
`ifdef VIDEO_SIG_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        pixel_rst;
  logic        video_hs, video_vs, video_blank;
  logic [23:0] video_rgb;
  logic        locked, frame_done, frame_ok, line_err;
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
  logic [11:0] meas_hact;
  logic [10:0] meas_vact;
  logic [31:0] frame_sig;

  always #5 clk = ~clk;

  video_sink_checker #(.HDISP(HD), .VDISP(VD), .LOCK_FRAMES(LF)) dut (
    .pixel_clk(clk), .pixel_rst(pixel_rst), .video_hs(video_hs), .video_vs(video_vs),
    .video_blank(video_blank), .video_rgb(video_rgb), .locked(locked),
    .frame_done(frame_done), .frame_ok(frame_ok), .line_err(line_err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt), .meas_hact(meas_hact),
    .meas_vact(meas_vact), .frame_sig(frame_sig)
  );

  typedef struct packed {
    logic        ok;
    logic [10:0] vact;
    logic [31:0] sig;
    logic [15:0] fcnt;
    logic        lck;
    logic [7:0]  err;
    logic        lerr;
    logic [11:0] hact;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  logic        m_synced, m_locked, m_lerr, m_bad;
  int          m_good, m_lines;
  logic [7:0]  m_err;
  logic [15:0] m_fcnt;
  logic [11:0] m_last;
  logic [31:0] m_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] sig_step(input logic [31:0] a, input logic [23:0] rgb);
    return {a[30:0], a[31]} ^ {8'h00, rgb};
  endfunction

  task automatic m_clear();
    m_synced = 1'b0; m_locked = 1'b0; m_lerr = 1'b0; m_bad = 1'b0;
    m_good = 0; m_lines = 0; m_err = 8'd0; m_fcnt = 16'd0; m_last = 12'd0; m_acc = 32'h0;
  endtask

  task automatic cyc(input logic hs, input logic vs, input logic blank, input logic [23:0] rgb);
    video_hs = hs; video_vs = vs; video_blank = blank; video_rgb = rgb;
    @(posedge clk); #1;
  endtask

  task automatic pix(input logic vs, input logic [23:0] rgb);
    m_acc = sig_step(m_acc, rgb);
    cyc(1'b1, vs, 1'b1, rgb);
  endtask

  task automatic line(input int len, input logic [23:0] first, input logic [23:0] rest);
    for (int i = 0; i < len; i++) pix(1'b1, (i == 0) ? first : rest);
    cyc(1'b1, 1'b1, 1'b0, 24'h0); cyc(1'b0, 1'b1, 1'b0, 24'h0);
    cyc(1'b0, 1'b1, 1'b0, 24'h0); cyc(1'b1, 1'b1, 1'b0, 24'h0);
    m_lines++;
    if (len != HD) m_bad = 1'b1;
    if (m_synced) begin
      m_last = 12'(len);
      if (len != HD) m_lerr = 1'b1;
    end
  endtask

  // frame-close model: pushes the expected report (first VS after reset only syncs)
  task automatic close_frame(input logic extra_bad);
    exp_t e;
    logic ok;
    if (m_synced) begin
      ok = !m_bad && !extra_bad && (m_lines == VD);
      m_fcnt++;
      if (ok) begin
        if (!m_locked) begin
          m_good++;
          if (m_good >= LF) m_locked = 1'b1;
        end
      end else begin
        m_good = 0; m_locked = 1'b0;
        if (m_err != 8'd255) m_err++;
      end
      e.ok = ok; e.vact = 11'(m_lines); e.sig = SIG_EN ? m_acc : 32'h0;
      e.fcnt = m_fcnt; e.lck = m_locked; e.err = m_err; e.lerr = m_lerr; e.hact = m_last;
      sb.push_back(e);
    end
    m_synced = 1'b1; m_lines = 0; m_bad = 1'b0; m_acc = 32'h0;
  endtask

  task automatic vsync();
    logic d2, d3, exp_done;
    exp_done = m_synced;
    close_frame(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 24'h0);
    cyc(1'b1, 1'b0, 1'b0, 24'h0); d2 = frame_done;
    cyc(1'b1, 1'b1, 1'b0, 24'h0); d3 = frame_done;
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
    chk("done_latency", 64'({d2, d3}), exp_done ? 64'd1 : 64'd0);
  endtask

  // scoreboard consumer
  always @(negedge clk) begin
    exp_t e;
    if (frame_done === 1'b1) begin
      chk("done_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("frame_ok", 64'(frame_ok), 64'(e.ok));
        chk("meas_vact", 64'(meas_vact), 64'(e.vact));
        chk("frame_sig", 64'(frame_sig), 64'(e.sig));
        chk("frame_cnt", 64'(frame_cnt), 64'(e.fcnt));
        chk("locked", 64'(locked), 64'(e.lck));
        chk("err_cnt", 64'(err_cnt), 64'(e.err));
        chk("line_err", 64'(line_err), 64'(e.lerr));
        chk("meas_hact", 64'(meas_hact), 64'(e.hact));
      end
    end
  end

  initial begin
    int seen;
    m_clear();
    pixel_rst = 1'b1;
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    chk("rst_outputs", 64'({locked, frame_done, frame_ok, line_err, frame_cnt, err_cnt,
                            meas_hact, meas_vact}), 64'd0);
    chk("rst_sig", 64'(frame_sig), 64'd0);
    pixel_rst = 1'b0;

    // idle after reset: no frame reports
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 24'h0);
      if (frame_done) seen++;
    end
    chk("idle_no_done", 64'(seen), 64'd0);

    // three correct frames, lock on the third VS
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < VD; l++) line(HD, 24'h123456, 24'h00A5C3);
      vsync();
    end
    chk("lock_after_3", 64'(locked), 64'd1);
    chk("hact_16", 64'(meas_hact), 64'd16);
    chk("vact_8", 64'(meas_vact), 64'd8);
    chk("err_0", 64'(err_cnt), 64'd0);

    // one 15-pixel line while locked
    for (int l = 0; l < VD; l++) line((l == 3) ? 15 : HD, 24'h0, 24'h000F00);
    vsync();
    chk("short_line_err", 64'(line_err), 64'd1);
    chk("short_err_cnt", 64'(err_cnt), 64'd1);
    chk("short_unlock", 64'(locked), 64'd0);
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < VD; l++) line(HD, 24'h0, 24'h0);
      vsync();
    end
    chk("relock", 64'(locked), 64'd1);

    // 7-line frame
    for (int l = 0; l < VD - 1; l++) line(HD, 24'h0, 24'h0);
    vsync();
    chk("vact_7", 64'(meas_vact), 64'd7);

    // active run spanning the VS fall; the VS-fall pixel closes the old frame
    for (int l = 0; l < VD; l++) line(HD, 24'h0, 24'h0);
    for (int i = 0; i < 8; i++) pix(1'b1, 24'h0);
    pix(1'b0, 24'h000001);
    close_frame(1'b1);
    pix(1'b0, 24'h0);
    for (int i = 0; i < 6; i++) pix(1'b1, 24'h0);
    repeat (4) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    m_lines = 1; m_last = 12'd16;
    chk("span_ok", 64'(frame_ok), 64'd0);
    for (int l = 0; l < VD - 1; l++) line(HD, 24'h0, 24'h0);
    vsync();

    // signatures
    for (int l = 0; l < VD; l++) line(HD, 24'h000001, 24'h000001);
    vsync();
    chk("sig_ones", 64'(frame_sig), 64'd0);
    line(HD, 24'hFFFFFF, 24'h0);
    for (int l = 1; l < VD; l++) line(HD, 24'h0, 24'h0);
    vsync();
    chk("sig_first", 64'(frame_sig), SIG_EN ? 64'h807F_FFFF : 64'd0);
    chk("locked_pre_rst", 64'(locked), 64'd1);

    // reset mid-frame while locked
    for (int l = 0; l < 4; l++) line(HD, 24'h0, 24'h0);
    pixel_rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 24'h0);
    pixel_rst = 1'b0;
    chk("midrst_outputs", 64'({locked, frame_done, frame_ok, line_err, frame_cnt, err_cnt,
                               meas_hact, meas_vact}), 64'd0);
    chk("midrst_sig", 64'(frame_sig), 64'd0);
    m_clear();
    for (int l = 0; l < 3; l++) line(HD, 24'h0, 24'h0);
    vsync();
    for (int f = 0; f < 2; f++) begin
      for (int l = 0; l < VD; l++) line(HD, 24'h0, 24'h0);
      vsync();
    end
    chk("relock_after_rst", 64'(locked), 64'd1);
    chk("err_after_rst", 64'(err_cnt), 64'd0);

    // empty frames drive err_cnt into saturation
    for (int f = 0; f < 260; f++) vsync();
    chk("err_saturated", 64'(err_cnt), 64'd255);
    chk("unlocked_sat", 64'(locked), 64'd0);

    repeat (6) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
